// File: rtl/csi_rx_pkg.sv
// Shared types and helpers for the CSI-2 receive lane word aligner.
//   wa_state_t  : word-aligner FSM states
//   BYTE_W      : width of one lane byte
//   clamp_lanes : maps a requested lane count onto 1..max_lanes
package csi_rx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {IDLE, WAIT_ALL, ALIGNED, ERROR} wa_state_t;

    // A request of 0 or more lanes than are built means "use all of them".
    function automatic int unsigned clamp_lanes(input int unsigned req,
                                                input int unsigned max_lanes);
        return (req == 0 || req > max_lanes) ? max_lanes : req;
    endfunction

endpackage

// File: rtl/csi_rx_n_lane_word_align_if.sv
// Bus between the packet-handler side and the lane word aligner.
//   master : drives enable, active_lanes, wait_for_sync, packet_done,
//            byte_in, valid_in; receives the aligned word and status
//   slave  : the aligner itself
interface csi_rx_n_lane_word_align_if #(
    parameter int NUM_LANES = 4,
    parameter int MAX_SKEW  = 4,
    parameter int ERR_CNT_W = 8
);
    import csi_rx_pkg::*;

    localparam int AL_W = $clog2(NUM_LANES) + 1;
    localparam int MS_W = $clog2(MAX_SKEW);

    logic                          enable;
    logic [AL_W-1:0]               active_lanes;
    logic                          wait_for_sync;
    logic                          packet_done;
    logic [BYTE_W*NUM_LANES-1:0]   byte_in;
    logic [NUM_LANES-1:0]          valid_in;
    logic [BYTE_W*NUM_LANES-1:0]   word_out;
    logic                          valid_out;
    logic                          packet_done_out;
    logic                          skew_err;
    logic [ERR_CNT_W-1:0]          skew_err_cnt;
    logic [MS_W-1:0]               max_skew_seen;

    modport master (
        output enable, active_lanes, wait_for_sync, packet_done, byte_in, valid_in,
        input  word_out, valid_out, packet_done_out, skew_err, skew_err_cnt, max_skew_seen
    );

    modport slave (
        input  enable, active_lanes, wait_for_sync, packet_done, byte_in, valid_in,
        output word_out, valid_out, packet_done_out, skew_err, skew_err_cnt, max_skew_seen
    );

endinterface

// File: rtl/csi_rx_lane_delay.sv
// Per-lane byte delay line with a tap mux.
//   clk, rst_n : byte clock, async active-low reset
//   en         : shift enable (line holds when low)
//   byte_in    : current lane byte (tap 0)
//   tap        : delay in cycles, 0..MAX_SKEW-1
//   byte_out   : byte_in delayed by tap cycles
module csi_rx_lane_delay
    import csi_rx_pkg::*;
#(
    parameter  int MAX_SKEW = 4,
    localparam int TAP_W    = $clog2(MAX_SKEW)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic [TAP_W-1:0]  tap,
    output logic [BYTE_W-1:0] byte_out
);
    localparam int DEPTH = MAX_SKEW - 1;
    localparam int DL_N  = 2 ** TAP_W;

    logic [DEPTH-1:0][BYTE_W-1:0] sr_q, sr_d;
    logic [DL_N-1:0][BYTE_W-1:0]  dl;

    always_comb begin
        sr_d = sr_q;
        if (en) begin
            sr_d[0] = byte_in;
            for (int k = 1; k < DEPTH; k++) sr_d[k] = sr_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    // Tap k = k cycles of delay; unreachable taps (non power-of-two depth) read 0.
    for (genvar k = 0; k < DL_N; k++) begin : g_tap
        if (k == 0) begin : g_now
            assign dl[k] = byte_in;
        end else if (k < MAX_SKEW) begin : g_old
            assign dl[k] = sr_q[k-1];
        end else begin : g_none
            assign dl[k] = '0;
        end
    end

    assign byte_out = dl[tap];

endmodule

// File: rtl/csi_rx_n_lane_word_align.sv
// N-lane CSI-2 word aligner: removes inter-lane skew of up to MAX_SKEW-1
// byte clocks and emits one lane-aligned word per byte clock.
//   byte_clock, reset_n : clock, async active-low reset
//   bus (slave)         : enable, active_lanes, wait_for_sync, packet_done,
//                         byte_in/valid_in in; word_out/valid_out,
//                         packet_done_out, skew_err, skew_err_cnt,
//                         max_skew_seen out (all registered)
module csi_rx_n_lane_word_align
    import csi_rx_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int MAX_SKEW  = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                              byte_clock,
    input  logic                              reset_n,
    csi_rx_n_lane_word_align_if.slave         bus
);
    localparam int AL_W = $clog2(NUM_LANES) + 1;
    localparam int MS_W = $clog2(MAX_SKEW);
    localparam int SC_W = MS_W + 1;

    wa_state_t                        state_q, state_d;
    logic [AL_W-1:0]                  nlanes_q, nlanes_d;
    logic [SC_W-1:0]                  skew_cnt_q, skew_cnt_d;
    logic [NUM_LANES-1:0]             arrived_q, arrived_d;
    logic [NUM_LANES-1:0][MS_W-1:0]   arr_q, arr_d;
    logic [NUM_LANES-1:0][MS_W-1:0]   tap_q, tap_d;
    logic [NUM_LANES-1:0][BYTE_W-1:0] word_out_q, word_out_d;
    logic                             valid_out_q, valid_out_d;
    logic                             pdo_q, pdo_d;
    logic                             skew_err_q, skew_err_d;
    logic [ERR_CNT_W-1:0]             err_cnt_q, err_cnt_d;
    logic [MS_W-1:0]                  max_skew_q, max_skew_d;

    logic [NUM_LANES-1:0]             lane_mask;
    logic [NUM_LANES-1:0]             vld_act;
    logic [NUM_LANES-1:0]             new_arr;
    logic [NUM_LANES-1:0][BYTE_W-1:0] lane_byte;

    // Delay lines look up tap_d so the word registered on the aligning
    // cycle already uses the freshly computed taps.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        csi_rx_lane_delay #(.MAX_SKEW(MAX_SKEW)) u_dly (
            .clk      (byte_clock),
            .rst_n    (reset_n),
            .en       (bus.enable),
            .byte_in  (bus.byte_in[l*BYTE_W +: BYTE_W]),
            .tap      (tap_d[l]),
            .byte_out (lane_byte[l])
        );
    end

    always_comb begin
        state_d    = state_q;
        nlanes_d   = nlanes_q;
        skew_cnt_d = skew_cnt_q;
        arrived_d  = arrived_q;
        arr_d      = arr_q;
        tap_d      = tap_q;
        pdo_d      = 1'b0;
        skew_err_d = skew_err_q;
        err_cnt_d  = err_cnt_q;
        max_skew_d = max_skew_q;
        new_arr    = '0;

        if (state_q == IDLE)
            nlanes_d = AL_W'(clamp_lanes(32'(bus.active_lanes), NUM_LANES));

        for (int l = 0; l < NUM_LANES; l++) lane_mask[l] = (l < int'(nlanes_d));
        vld_act = bus.valid_in & lane_mask;

        case (state_q)
            IDLE: begin
                skew_cnt_d = '0;
                arrived_d  = '0;
                arr_d      = '0;
                tap_d      = '0;
                if (bus.wait_for_sync && (|vld_act)) begin
                    arrived_d  = vld_act;
                    skew_err_d = 1'b0;
                    // The arming cycle counts as skew 0, so the first WAIT_ALL
                    // cycle already sits at skew 1.
                    if (vld_act == lane_mask) begin
                        state_d = ALIGNED;
                    end else begin
                        state_d    = WAIT_ALL;
                        skew_cnt_d = SC_W'(1);
                    end
                end
            end
            WAIT_ALL: begin
                new_arr   = vld_act & ~arrived_q;
                arrived_d = arrived_q | vld_act;
                for (int l = 0; l < NUM_LANES; l++)
                    if (new_arr[l]) arr_d[l] = skew_cnt_q[MS_W-1:0];
                if (bus.packet_done) begin
                    state_d = IDLE;
                    pdo_d   = 1'b1;
                end else if (arrived_d == lane_mask) begin
                    state_d = ALIGNED;
                    for (int l = 0; l < NUM_LANES; l++)
                        tap_d[l] = lane_mask[l] ? skew_cnt_q[MS_W-1:0] - arr_d[l] : '0;
                    if (skew_cnt_q[MS_W-1:0] > max_skew_q)
                        max_skew_d = skew_cnt_q[MS_W-1:0];
                end else if (skew_cnt_q == SC_W'(MAX_SKEW - 1)) begin
                    state_d = ERROR;
                    pdo_d   = 1'b1;
                end else begin
                    skew_cnt_d = skew_cnt_q + 1'b1;
                end
            end
            ALIGNED: begin
                if (bus.packet_done) begin
                    state_d = IDLE;
                    pdo_d   = 1'b1;
                end else if (vld_act != lane_mask) begin
                    state_d = ERROR;
                    pdo_d   = 1'b1;
                end
            end
            default: begin  // ERROR: one cycle, then re-arm from IDLE
                state_d    = IDLE;
                skew_err_d = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            end
        endcase

        valid_out_d = (state_d == ALIGNED);
        for (int l = 0; l < NUM_LANES; l++)
            word_out_d[l] = (valid_out_d && lane_mask[l]) ? lane_byte[l] : '0;
    end

    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            nlanes_q    <= '0;
            skew_cnt_q  <= '0;
            arrived_q   <= '0;
            arr_q       <= '0;
            tap_q       <= '0;
            word_out_q  <= '0;
            valid_out_q <= 1'b0;
            pdo_q       <= 1'b0;
            skew_err_q  <= 1'b0;
            err_cnt_q   <= '0;
            max_skew_q  <= '0;
        end else if (bus.enable) begin
            state_q     <= state_d;
            nlanes_q    <= nlanes_d;
            skew_cnt_q  <= skew_cnt_d;
            arrived_q   <= arrived_d;
            arr_q       <= arr_d;
            tap_q       <= tap_d;
            word_out_q  <= word_out_d;
            valid_out_q <= valid_out_d;
            pdo_q       <= pdo_d;
            skew_err_q  <= skew_err_d;
            err_cnt_q   <= err_cnt_d;
            max_skew_q  <= max_skew_d;
        end
    end

    assign bus.word_out        = word_out_q;
    assign bus.valid_out       = valid_out_q;
    assign bus.packet_done_out = pdo_q;
    assign bus.skew_err        = skew_err_q;
    assign bus.skew_err_cnt    = err_cnt_q;
    assign bus.max_skew_seen   = max_skew_q;

endmodule

// File: tb/tb_csi_rx_n_lane_word_align.sv
// Self-checking bench for csi_rx_n_lane_word_align (4 lanes, skew depth 4).
// A cycle-level reference model keeps a byte history per lane and derives
// each output word from lane arrival times; directed cases follow, then
// randomized packets.
module tb_csi_rx_n_lane_word_align;
    import csi_rx_pkg::*;

    localparam int NL = 4;
    localparam int MS = 4;
    localparam int CW = 8;
    localparam int HN = 8192;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csi_rx_n_lane_word_align_if #(.NUM_LANES(NL), .MAX_SKEW(MS), .ERR_CNT_W(CW)) bus();

    csi_rx_n_lane_word_align #(.NUM_LANES(NL), .MAX_SKEW(MS), .ERR_CNT_W(CW)) dut (
        .byte_clock (clk),
        .reset_n    (rst_n),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  hist [NL][HN];
    int          cyc;
    int          first [NL];
    int          tap [NL];
    int          m_nl, m_t0;
    bit          m_wait, m_lock, m_errp;
    logic [31:0] e_word;
    bit          e_vld, e_pdo, e_err;
    int          e_cnt, e_max;

    function automatic int m_clamp(input int a);
        return (a == 0 || a > NL) ? NL : a;
    endfunction

    task automatic model_reset();
        cyc = 0; m_nl = NL; m_t0 = 0;
        m_wait = 0; m_lock = 0; m_errp = 0;
        e_word = '0; e_vld = 0; e_pdo = 0; e_err = 0; e_cnt = 0; e_max = 0;
        for (int l = 0; l < NL; l++) begin first[l] = -1; tap[l] = 0; end
    endtask

    // When every active lane has a first-arrival cycle, lock: each lane's
    // delay is the gap between the last arrival (now) and its own arrival.
    task automatic lock_if_complete(output bit ok);
        ok = 1;
        for (int l = 0; l < m_nl; l++) if (first[l] < 0) ok = 0;
        if (ok) begin
            for (int l = 0; l < m_nl; l++) tap[l] = cyc - first[l];
            if (cyc - m_t0 > e_max) e_max = cyc - m_t0;
            m_lock = 1;
        end
    endtask

    // Predicts the registered outputs after the coming rising edge.
    task automatic model_eval();
        logic [31:0] n_word;
        bit n_vld, n_pdo, emit_now, drop, any;
        n_word = '0; n_vld = 0; n_pdo = 0; emit_now = 0;
        for (int l = 0; l < NL; l++) hist[l][cyc % HN] = bus.byte_in[8*l +: 8];

        if (m_errp) begin
            m_errp = 0;
            e_err  = 1;
            if (e_cnt < 255) e_cnt++;
        end else if (m_lock) begin
            if (bus.packet_done) begin
                m_lock = 0; n_pdo = 1;
            end else begin
                drop = 0;
                for (int l = 0; l < m_nl; l++) if (!bus.valid_in[l]) drop = 1;
                if (drop) begin m_lock = 0; m_errp = 1; n_pdo = 1; end
                else emit_now = 1;
            end
        end else if (m_wait) begin
            if (bus.packet_done) begin
                m_wait = 0; n_pdo = 1;
            end else begin
                for (int l = 0; l < m_nl; l++)
                    if (bus.valid_in[l] && first[l] < 0) first[l] = cyc;
                lock_if_complete(emit_now);
                if (emit_now) m_wait = 0;
                else if (cyc - m_t0 == MS - 1) begin m_wait = 0; m_errp = 1; n_pdo = 1; end
            end
        end else if (bus.wait_for_sync) begin
            m_nl = m_clamp(int'(bus.active_lanes));
            any = 0;
            for (int l = 0; l < NL; l++) begin
                first[l] = -1;
                if (l < m_nl && bus.valid_in[l]) begin first[l] = cyc; any = 1; end
            end
            if (any) begin
                m_t0  = cyc;
                e_err = 0;
                lock_if_complete(emit_now);
                if (!emit_now) m_wait = 1;
            end
        end

        if (emit_now) begin
            n_vld = 1;
            for (int l = 0; l < m_nl; l++) n_word[8*l +: 8] = hist[l][(cyc - tap[l]) % HN];
        end
        e_word = n_word; e_vld = n_vld; e_pdo = n_pdo;
        cyc++;
    endtask

    // One byte clock: predict, clock, compare every output.
    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        chk("word_out",        64'(bus.word_out),        64'(e_word));
        chk("valid_out",       64'(bus.valid_out),       64'(e_vld));
        chk("packet_done_out", 64'(bus.packet_done_out), 64'(e_pdo));
        chk("skew_err",        64'(bus.skew_err),        64'(e_err));
        chk("skew_err_cnt",    64'(bus.skew_err_cnt),    64'(e_cnt));
        chk("max_skew_seen",   64'(bus.max_skew_seen),   64'(e_max));
        @(negedge clk);
    endtask

    // ---------------- packet driver ----------------
    int          p_al, p_len, p_pd, p_dl, p_da;
    int          p_off [NL];
    logic [7:0]  p_fb [NL];
    bit          p_usefb;
    int          r_fv, r_pdo, r_vld;
    logic [31:0] r_fw;
    logic [15:0] r_up;

    task automatic run_pkt();
        logic [31:0] bi;
        logic [3:0]  vi;
        bit          in_pkt;
        int          nl;
        r_fv = -1; r_fw = '0; r_pdo = 0; r_vld = 0; r_up = '0;
        nl = m_clamp(p_al);
        bus.active_lanes = 3'(p_al);
        for (int c = 0; c < p_len + 3; c++) begin
            in_pkt = (c < p_len);
            bus.wait_for_sync = in_pkt;
            bus.packet_done   = in_pkt && (c == p_pd);
            for (int l = 0; l < NL; l++) begin
                if (l >= nl) vi[l] = 1'($urandom_range(0, 1));
                else         vi[l] = in_pkt && (c >= p_off[l]) && !(l == p_dl && c >= p_da);
                bi[8*l +: 8] = (p_usefb && c == p_off[l]) ? p_fb[l] : 8'($urandom);
            end
            bus.valid_in = vi;
            bus.byte_in  = bi;
            tick();
            if (bus.valid_out) begin
                r_vld++;
                if (r_fv < 0) begin r_fv = c + 1; r_fw = bus.word_out; end
            end
            if (bus.packet_done_out) r_pdo++;
            r_up = r_up | bus.word_out[31:16];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_pkt(input int al, input int o0, input int o1, input int o2, input int o3,
                           input int len, input int pd, input int dl, input int da);
        p_al = al; p_len = len; p_pd = pd; p_dl = dl; p_da = da;
        p_off[0] = o0; p_off[1] = o1; p_off[2] = o2; p_off[3] = o3;
        p_usefb = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b1; bus.active_lanes = '0; bus.wait_for_sync = 1'b0;
        bus.packet_done = 1'b0; bus.byte_in = '0; bus.valid_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_word_out",  64'(bus.word_out),        64'd0);
        chk("rst_valid_out", 64'(bus.valid_out),       64'd0);
        chk("rst_pdo",       64'(bus.packet_done_out), 64'd0);
        chk("rst_skew_err",  64'(bus.skew_err),        64'd0);
        chk("rst_err_cnt",   64'(bus.skew_err_cnt),    64'd0);
        chk("rst_max_skew",  64'(bus.max_skew_seen),   64'd0);
        rst_n = 1'b1;

        // Skewed arrival 0,1,2,1 -> taps 2,1,0,1.
        set_pkt(4, 0, 1, 2, 1, 8, 7, -1, 0);
        p_usefb = 1; p_fb[0] = 8'hB8; p_fb[1] = 8'hA1; p_fb[2] = 8'hB2; p_fb[3] = 8'hC3;
        run_pkt();
        chk("skew_first_cycle", 64'(r_fv), 64'd3);
        chk("skew_first_word",  64'(r_fw), 64'hC3B2A1B8);
        chk("skew_max_seen",    64'(bus.max_skew_seen), 64'd2);

        // All lanes together -> taps 0, valid the next cycle.
        set_pkt(4, 0, 0, 0, 0, 6, 5, -1, 0);
        p_usefb = 1; p_fb[0] = 8'h11; p_fb[1] = 8'h22; p_fb[2] = 8'h33; p_fb[3] = 8'h44;
        run_pkt();
        chk("same_first_cycle", 64'(r_fv), 64'd1);
        chk("same_first_word",  64'(r_fw), 64'h44332211);

        // Lane 3 never arrives -> timeout error.
        set_pkt(4, 0, 0, 0, 99, 5, -1, -1, 0);
        run_pkt();
        chk("tmo_pdo_pulses", 64'(r_pdo), 64'd1);
        chk("tmo_valid_cnt",  64'(r_vld), 64'd0);
        chk("tmo_skew_err",   64'(bus.skew_err), 64'd1);
        chk("tmo_err_cnt",    64'(bus.skew_err_cnt), 64'd1);

        // Two active lanes; lanes 2-3 toggle randomly and must be ignored.
        set_pkt(2, 0, 2, 0, 0, 10, 9, -1, 0);
        run_pkt();
        chk("two_upper_zero", 64'(r_up), 64'd0);
        chk("two_valid_cnt",  64'(r_vld), 64'd7);
        chk("two_skew_err",   64'(bus.skew_err), 64'd0);
        chk("two_err_cnt",    64'(bus.skew_err_cnt), 64'd1);

        // Lane drop while aligned, repeated to saturate the counter.
        for (int i = 0; i < 300; i++) begin
            set_pkt(4, 0, 0, 0, 0, 4, -1, 1, 2);
            run_pkt();
        end
        chk("drop_pdo_pulses", 64'(r_pdo), 64'd1);
        chk("drop_err_cnt_sat", 64'(bus.skew_err_cnt), 64'd255);

        // packet_done and lane drop together: packet_done wins.
        do_reset();
        set_pkt(4, 0, 0, 0, 0, 4, 3, 1, 3);
        run_pkt();
        chk("pd_drop_skew_err", 64'(bus.skew_err), 64'd0);
        chk("pd_drop_err_cnt",  64'(bus.skew_err_cnt), 64'd0);
        chk("pd_drop_pdo",      64'(r_pdo), 64'd1);

        // Asynchronous reset while aligned.
        bus.active_lanes = 3'd4; bus.wait_for_sync = 1'b1; bus.packet_done = 1'b0;
        bus.valid_in = 4'hF;
        for (int i = 0; i < 2; i++) begin
            bus.byte_in = $urandom;
            tick();
        end
        chk("mid_rst_pre_valid", 64'(bus.valid_out), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_word",   64'(bus.word_out), 64'd0);
        chk("mid_rst_valid",  64'(bus.valid_out), 64'd0);
        chk("mid_rst_pdo",    64'(bus.packet_done_out), 64'd0);
        chk("mid_rst_state",  64'(dut.state_q), 64'(IDLE));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.wait_for_sync = 1'b0; bus.valid_in = '0;

        // Randomized packets: lane count (incl. 0 and >4), skews up to 4
        // (4 times out), early/absent packet_done, random lane drops.
        for (int i = 0; i < 150; i++) begin
            int len, sel;
            len = $urandom_range(3, 10);
            sel = $urandom_range(0, 3);
            set_pkt($urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 4), len,
                    (sel == 0) ? -1 : (sel == 1) ? $urandom_range(0, len - 1) : len - 1,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, NL - 1) : -1,
                    $urandom_range(0, len - 1));
            run_pkt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
